// File: rtl/spart_fifo.sv
// spart_fifo: UART with TX/RX character FIFOs behind a 4-register bus (DBUF, SREG, DBL, DBH).
// Optional build macro SPART_LOOPBACK_EN feeds the receiver from the internal txd line.

module spart_fifo_buf #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [3:0]       count,
  output logic             full,
  output logic             empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;

  assign dout  = mem[rptr];
  assign full  = (count == 4'(DEPTH));
  assign empty = (count == 4'd0);

  // push/pop arrive already qualified against full/empty by the owner
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= 4'd0;
    end else begin
      if (push) wptr <= (wptr == PW'(DEPTH - 1)) ? '0 : wptr + 1'b1;
      if (pop)  rptr <= (rptr == PW'(DEPTH - 1)) ? '0 : rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 4'd1;
        2'b01:   count <= count - 4'd1;
        default: count <= count;
      endcase
    end
  end
endmodule

// state    | meaning (shared encoding for the TX and RX framers)
// ST_IDLE  | line idle, waiting for a character (TX) or a falling edge (RX)
// ST_START | start bit period (RX: half period, then start re-check)
// ST_DATA  | DATA_W data bits, LSB first
// ST_STOP  | stop bit period (RX: stop sample decides push or discard)
module spart_fifo #(
  parameter int          DATA_W     = 8,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd325
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic       rd_en,
  input  logic [1:0] ioaddr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       txd,
  input  logic       rxd
);
  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} frame_state_t;

  localparam logic [1:0] A_DBUF = 2'b00;
  localparam logic [1:0] A_SREG = 2'b01;
  localparam logic [1:0] A_DBL  = 2'b10;
  localparam logic [1:0] A_DBH  = 2'b11;

  logic        bus_wr;
  logic        bus_rd;
  logic [15:0] divisor;

  logic              tx_push, tx_pop, tx_full, tx_empty;
  logic [DATA_W-1:0] tx_head;
  logic [3:0]        tx_count;
  logic              rx_push, rx_pop, rx_full, rx_empty;
  logic [DATA_W-1:0] rx_head;
  logic [3:0]        rx_count;
  logic [3:0]        tx_free;

  // simultaneous strobes are treated as no access at all
  assign bus_wr = wr_en & ~rd_en;
  assign bus_rd = rd_en & ~wr_en;

  assign tx_push = bus_wr & (ioaddr == A_DBUF) & ~tx_full;
  assign rx_pop  = bus_rd & (ioaddr == A_DBUF) & ~rx_empty;
  assign tx_free = 4'(FIFO_DEPTH) - tx_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      divisor <= DIV_RESET;
    end else if (bus_wr && ioaddr == A_DBL) begin
      divisor[7:0] <= wdata;
    end else if (bus_wr && ioaddr == A_DBH) begin
      divisor[15:8] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= 8'h00;
    end else if (bus_rd) begin
      unique case (ioaddr)
        A_DBUF: rdata <= rx_empty ? 8'h00 : 8'(rx_head);
        A_SREG: rdata <= {tx_free, rx_count};
        A_DBL:  rdata <= divisor[7:0];
        A_DBH:  rdata <= divisor[15:8];
      endcase
    end
  end

  spart_fifo_buf #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .pop   (tx_pop),
    .din   (wdata[DATA_W-1:0]),
    .dout  (tx_head),
    .count (tx_count),
    .full  (tx_full),
    .empty (tx_empty)
  );

  // ---------------- transmitter ----------------
  frame_state_t      tx_state, tx_state_nxt;
  logic [15:0]       tx_timer, tx_timer_nxt;
  logic [15:0]       tx_div, tx_div_nxt;
  logic [DATA_W-1:0] tx_shift, tx_shift_nxt;
  logic [3:0]        tx_bit, tx_bit_nxt;
  logic              txd_nxt;
  logic              tx_tc;
  logic              tx_load;

  assign tx_tc = (tx_timer == 16'd0);
  // a new frame starts from idle, or straight out of a finished stop bit
  assign tx_load = ~tx_empty &
                   ((tx_state == ST_IDLE) || (tx_state == ST_STOP && tx_tc));
  assign tx_pop = tx_load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= ST_IDLE;
      tx_timer <= 16'd0;
      tx_div   <= 16'd0;
      tx_shift <= '0;
      tx_bit   <= 4'd0;
      txd      <= 1'b1;
    end else begin
      tx_state <= tx_state_nxt;
      tx_timer <= tx_timer_nxt;
      tx_div   <= tx_div_nxt;
      tx_shift <= tx_shift_nxt;
      tx_bit   <= tx_bit_nxt;
      txd      <= txd_nxt;
    end
  end

  always_comb begin
    tx_state_nxt = tx_state;
    tx_timer_nxt = tx_timer;
    tx_div_nxt   = tx_div;
    tx_shift_nxt = tx_shift;
    tx_bit_nxt   = tx_bit;
    txd_nxt      = 1'b1;
    if (tx_load) begin
      tx_state_nxt = ST_START;
      tx_div_nxt   = divisor;
      tx_timer_nxt = divisor;
      tx_shift_nxt = tx_head;
    end else begin
      case (tx_state)
        ST_IDLE: tx_state_nxt = ST_IDLE;
        ST_START: begin
          if (tx_tc) begin
            tx_state_nxt = ST_DATA;
            tx_timer_nxt = tx_div;
            tx_bit_nxt   = 4'd0;
          end else begin
            tx_timer_nxt = tx_timer - 16'd1;
          end
        end
        ST_DATA: begin
          if (tx_tc) begin
            tx_shift_nxt = tx_shift >> 1;
            tx_timer_nxt = tx_div;
            if (tx_bit == 4'(DATA_W - 1)) tx_state_nxt = ST_STOP;
            else                          tx_bit_nxt   = tx_bit + 4'd1;
          end else begin
            tx_timer_nxt = tx_timer - 16'd1;
          end
        end
        ST_STOP: begin
          if (tx_tc) tx_state_nxt = ST_IDLE;
          else       tx_timer_nxt = tx_timer - 16'd1;
        end
      endcase
    end
    case (tx_state_nxt)
      ST_START: txd_nxt = 1'b0;
      ST_DATA:  txd_nxt = tx_shift_nxt[0];
      default:  txd_nxt = 1'b1;
    endcase
  end

  // ---------------- receiver ----------------
  logic rx_src;
`ifdef SPART_LOOPBACK_EN
  assign rx_src = txd;
`else
  assign rx_src = rxd;
`endif

  logic rx_sync1, rx_s, rx_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_sync1 <= 1'b1;
      rx_s     <= 1'b1;
      rx_prev  <= 1'b1;
    end else begin
      rx_sync1 <= rx_src;
      rx_s     <= rx_sync1;
      rx_prev  <= rx_s;
    end
  end

  frame_state_t      rx_state, rx_state_nxt;
  logic [15:0]       rx_timer, rx_timer_nxt;
  logic [15:0]       rx_div, rx_div_nxt;
  logic [DATA_W-1:0] rx_shift, rx_shift_nxt;
  logic [3:0]        rx_bit, rx_bit_nxt;
  logic              rx_done;
  logic              rx_tc;

  assign rx_tc = (rx_timer == 16'd0);
  // a full FIFO still accepts when the bus pops in the same cycle
  assign rx_push = rx_done & (~rx_full | rx_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state <= ST_IDLE;
      rx_timer <= 16'd0;
      rx_div   <= 16'd0;
      rx_shift <= '0;
      rx_bit   <= 4'd0;
    end else begin
      rx_state <= rx_state_nxt;
      rx_timer <= rx_timer_nxt;
      rx_div   <= rx_div_nxt;
      rx_shift <= rx_shift_nxt;
      rx_bit   <= rx_bit_nxt;
    end
  end

  always_comb begin
    rx_state_nxt = rx_state;
    rx_timer_nxt = rx_timer;
    rx_div_nxt   = rx_div;
    rx_shift_nxt = rx_shift;
    rx_bit_nxt   = rx_bit;
    rx_done      = 1'b0;
    case (rx_state)
      ST_IDLE: begin
        if (rx_prev && !rx_s) begin
          rx_state_nxt = ST_START;
          rx_div_nxt   = divisor;
          rx_timer_nxt = {1'b0, divisor[15:1]};
        end
      end
      ST_START: begin
        if (rx_tc) begin
          if (rx_s) begin
            rx_state_nxt = ST_IDLE;
          end else begin
            rx_state_nxt = ST_DATA;
            rx_timer_nxt = rx_div;
            rx_bit_nxt   = 4'd0;
          end
        end else begin
          rx_timer_nxt = rx_timer - 16'd1;
        end
      end
      ST_DATA: begin
        if (rx_tc) begin
          rx_shift_nxt = {rx_s, rx_shift[DATA_W-1:1]};
          rx_timer_nxt = rx_div;
          if (rx_bit == 4'(DATA_W - 1)) rx_state_nxt = ST_STOP;
          else                          rx_bit_nxt   = rx_bit + 4'd1;
        end else begin
          rx_timer_nxt = rx_timer - 16'd1;
        end
      end
      ST_STOP: begin
        if (rx_tc) begin
          rx_state_nxt = ST_IDLE;
          rx_done      = rx_s;
        end else begin
          rx_timer_nxt = rx_timer - 16'd1;
        end
      end
    endcase
  end

  spart_fifo_buf #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .pop   (rx_pop),
    .din   (rx_shift),
    .dout  (rx_head),
    .count (rx_count),
    .full  (rx_full),
    .empty (rx_empty)
  );
endmodule

// File: tb/tb_spart_fifo.sv
// tb_spart_fifo: directed bench for spart_fifo (DATA_W=8, FIFO_DEPTH=8, divisor set to 4).
// Define SPART_LOOPBACK_EN to exercise the loopback build instead of the rxd path.

module tb_spart_fifo;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic [1:0] ioaddr = 2'b00;
  logic [7:0] wdata = 8'h00;
  logic [7:0] rdata;
  logic       txd;
  logic       rxd = 1'b1;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q [0:8];

  spart_fifo #(.DATA_W(8), .FIFO_DEPTH(8), .DIV_RESET(16'd325)) dut (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_en),
    .rd_en  (rd_en),
    .ioaddr (ioaddr),
    .wdata  (wdata),
    .rdata  (rdata),
    .txd    (txd),
    .rxd    (rxd)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    ioaddr = a;
    wdata  = d;
    wr_en  = 1'b1;
    @(negedge clk);
    wr_en  = 1'b0;
  endtask

  task automatic read_expect(input string tag, input logic [1:0] a, input logic [7:0] exp);
    @(negedge clk);
    ioaddr = a;
    rd_en  = 1'b1;
    @(negedge clk);
    rd_en  = 1'b0;
    check_val(tag, {8'h00, rdata}, {8'h00, exp});
  endtask

  task automatic wait_txd_low(input string tag, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (txd === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_val(tag, {15'd0, txd}, 16'd0);
  endtask

  // samples each bit at the third of its five cycles, frames assumed contiguous
  task automatic tx_watch(input int n);
    bit ok;
    logic [9:0] frame;
    wait_txd_low("tx_start_timeout", 80, ok);
    if (ok) begin
      for (int f = 0; f < n; f++) begin
        frame = '0;
        for (int k = 0; k < 10; k++) begin
          for (int c = 0; c < 5; c++) begin
            if (c == 2) frame[k] = txd;
            @(negedge clk);
          end
        end
        check_val($sformatf("tx_frame%0d", f), {6'd0, frame}, {6'd0, 1'b1, exp_q[f], 1'b0});
      end
    end
  endtask

  task automatic txd_idle_check(input string tag, input int cycles);
    logic seen_low;
    seen_low = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (txd !== 1'b1) seen_low = 1'b1;
    end
    check_val(tag, {15'd0, seen_low}, 16'd0);
  endtask

  task automatic rx_send(input logic [7:0] b, input logic stop_bit);
    logic [9:0] fr;
    fr = {stop_bit, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      rxd = fr[k];
      repeat (5) @(negedge clk);
    end
    rxd = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_val("reset_rdata", {8'h00, rdata}, 16'h0000);
    check_val("reset_txd", {15'd0, txd}, 16'd1);
    read_expect("reset_sreg", 2'b01, 8'h80);
    read_expect("reset_dbl", 2'b10, 8'h45);
    read_expect("reset_dbh", 2'b11, 8'h01);

    bus_wr(2'b10, 8'h04);
    bus_wr(2'b11, 8'h00);
    read_expect("dbh_write", 2'b11, 8'h00);
    read_expect("dbl_write", 2'b10, 8'h04);

    @(negedge clk);
    ioaddr = 2'b10;
    wdata  = 8'h99;
    rd_en  = 1'b1;
    wr_en  = 1'b1;
    @(negedge clk);
    rd_en  = 1'b0;
    wr_en  = 1'b0;
    check_val("rdwr_rdata_hold", {8'h00, rdata}, 16'h0004);
    read_expect("rdwr_dbl_kept", 2'b10, 8'h04);

`ifdef SPART_LOOPBACK_EN
    bus_wr(2'b00, 8'h5A);
    repeat (70) @(negedge clk);
    read_expect("loop_sreg", 2'b01, 8'h81);
    read_expect("loop_dbuf", 2'b00, 8'h5A);
    read_expect("loop_empty", 2'b00, 8'h00);
`else
    // single frame
    bus_wr(2'b00, 8'hA5);
    exp_q[0] = 8'hA5;
    tx_watch(1);
    txd_idle_check("tx_idle_after_a5", 20);
    read_expect("sreg_after_a5", 2'b01, 8'h80);

    // primer frame in flight, then nine back-to-back writes
    exp_q[0] = 8'hC3;
    for (int i = 1; i < 9; i++) exp_q[i] = 8'(i);
    bus_wr(2'b00, 8'hC3);
    fork
      tx_watch(9);
      begin
        repeat (3) @(negedge clk);
        for (int i = 0; i < 9; i++) begin
          ioaddr = 2'b00;
          wdata  = 8'(i + 1);
          wr_en  = 1'b1;
          @(negedge clk);
        end
        wr_en = 1'b0;
        read_expect("sreg_tx_full", 2'b01, 8'h00);
      end
    join
    txd_idle_check("tx_no_ninth", 80);
    read_expect("sreg_tx_drained", 2'b01, 8'h80);

    // receive path
    rx_send(8'h3C, 1'b1);
    repeat (10) @(negedge clk);
    read_expect("rx_sreg_one", 2'b01, 8'h81);
    read_expect("rx_dbuf_3c", 2'b00, 8'h3C);
    read_expect("rx_dbuf_empty", 2'b00, 8'h00);
    read_expect("rx_sreg_zero", 2'b01, 8'h80);

    rx_send(8'h55, 1'b0);
    repeat (10) @(negedge clk);
    read_expect("rx_framing_drop", 2'b01, 8'h80);

    rxd = 1'b0;
    repeat (2) @(negedge clk);
    rxd = 1'b1;
    repeat (20) @(negedge clk);
    read_expect("rx_glitch_drop", 2'b01, 8'h80);

    rx_send(8'hA7, 1'b1);
    repeat (10) @(negedge clk);
    read_expect("rx_after_glitch", 2'b00, 8'hA7);

    for (int i = 0; i < 9; i++) rx_send(8'h10 + 8'(i), 1'b1);
    repeat (10) @(negedge clk);
    read_expect("rx_sreg_full", 2'b01, 8'h88);
    for (int i = 0; i < 8; i++) read_expect($sformatf("rx_drain%0d", i), 2'b00, 8'h10 + 8'(i));
    read_expect("rx_overrun_dropped", 2'b00, 8'h00);
    read_expect("rx_sreg_drained", 2'b01, 8'h80);
`endif

    // reset in the middle of a frame
    bus_wr(2'b00, 8'hF0);
    wait_txd_low("rst_tx_start", 20, ok);
    repeat (12) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_val("rst_txd_immediate", {15'd0, txd}, 16'd1);
    @(negedge clk);
    rst = 1'b0;
    read_expect("rst_sreg", 2'b01, 8'h80);
    read_expect("rst_dbl", 2'b10, 8'h45);
    txd_idle_check("rst_no_resume", 60);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
